exception_controller: RTL and testbench

- Centralised exception/interrupt sequencer for the 5-stage pipelined MIPS CPU.
- Latches timer and UART-rx interrupt events and prioritises them against illegal-instruction detection.
- Drives the IF-stage PC redirect, IF/ID flush and EPC capture.
- Sequences the kernel-entry / eret-return handshake with a guard cycle so that user code always makes forward progress.

---
 rtl/exception_controller.sv | 168 ++++++++++++++++
 tb/tb_exception_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_controller.sv
// Exception/interrupt sequencer for the 5-stage MIPS pipeline.
// Latches timer and UART-rx events, prioritises them against illegal-instruction
// detection, redirects fetch to the handler vector, captures EPC and sequences
// the eret return through a one-cycle guard so user code always progresses.
// Optional build macro: EXC_MASK_EN adds a 2-bit source mask register
// (mask_we / mask_wdata / mask) that can block timer and rx takes.
module exception_controller #(
  parameter logic [31:0] VEC_BASE   = 32'h8000_0000,
  parameter int unsigned VEC_STRIDE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        timer_irq,
  input  logic        rx_irq,
  input  logic        illegal_inst,
  input  logic        eret,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_pc_seq,
  input  logic        if_is_jump,
`ifdef EXC_MASK_EN
  input  logic        mask_we,
  input  logic [1:0]  mask_wdata,
  output logic [1:0]  mask,
`endif
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush_if_id,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        kernel,
  output logic [2:0]  pending
);

  typedef enum logic [1:0] {StUser, StKernel, StGuard} state_e;

  localparam logic [1:0] IdxTimer   = 2'd0;
  localparam logic [1:0] IdxRx      = 2'd1;
  localparam logic [1:0] IdxIllegal = 2'd2;

  state_e      state_q, state_d;
  logic [2:0]  pending_q, pending_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  cause_q, cause_d;
  logic        kernel_q, kernel_d;

  logic [1:0]  src_mask;
  logic [1:0]  src_ok;
  logic        take;
  logic        ret;
  logic [1:0]  take_idx;

`ifdef EXC_MASK_EN
  logic [1:0] mask_q, mask_d;

  // Mask register write path; a write only affects takes from the next cycle.
  always_comb begin
    mask_d = mask_q;
    if (mask_we) begin
      mask_d = mask_wdata;
    end
  end

  // Mask register storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= 2'b00;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign src_mask = mask_q;
  assign mask     = mask_q;
`else
  assign src_mask = 2'b00;
`endif

  // Take / return decision and source priority (timer > rx > illegal).
  always_comb begin
    src_ok   = pending_q[1:0] & ~src_mask;
    take     = 1'b0;
    ret      = 1'b0;
    take_idx = IdxIllegal;
    if (src_ok[0]) begin
      take_idx = IdxTimer;
    end else if (src_ok[1]) begin
      take_idx = IdxRx;
    end
    if (!reset) begin
      // Kernel code reached by a jump from user mode must not be interrupted.
      take = (state_q == StUser) && !if_pc[31] && ((|src_ok) || illegal_inst);
      ret  = (state_q == StKernel) && eret;
    end
  end

  // Combinational PC-mux override and IF/ID flush.
  always_comb begin
    redirect    = take | ret;
    flush_if_id = take;
    redirect_pc = 32'h0;
    if (take) begin
      redirect_pc = VEC_BASE + (32'(VEC_STRIDE) * {30'h0, take_idx});
    end else if (ret) begin
      redirect_pc = epc_q;
    end
  end

  // Next-state for the sequencer, pending flags, EPC and cause.
  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    pending_d = pending_q;

    // A pulse that coincides with the take of its own source keeps the bit set.
    pending_d[0] = (pending_q[0] & ~(take && (take_idx == IdxTimer))) | timer_irq;
    pending_d[1] = (pending_q[1] & ~(take && (take_idx == IdxRx))) | rx_irq;
    // Illegal is never latched; this bit is an observation-only mirror.
    pending_d[2] = illegal_inst & ~(take && (take_idx == IdxIllegal));

    unique case (state_q)
      StUser: begin
        if (take) begin
          // Re-execute a branch so its delay slot is not lost.
          epc_d   = if_is_jump ? if_pc : if_pc_seq;
          cause_d = take_idx;
          state_d = StKernel;
        end
      end
      StKernel: begin
        if (ret) begin
          state_d = StGuard;
        end
      end
      StGuard: begin
        state_d = StUser;
      end
      default: begin
        state_d = StUser;
      end
    endcase

    kernel_d = (state_d != StUser);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StUser;
      pending_q <= 3'b000;
      epc_q     <= 32'h0;
      cause_q   <= 2'd0;
      kernel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      kernel_q  <= kernel_d;
    end
  end

  assign epc     = epc_q;
  assign cause   = cause_q;
  assign kernel  = kernel_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_exception_controller.sv
// Self-checking bench for exception_controller: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a behavioural model.
module tb_exception_controller;

  localparam logic [31:0] VecBase = 32'h8000_0000;
  localparam int          Stride  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        timer_irq, rx_irq, illegal_inst, eret, if_is_jump;
  logic [31:0] if_pc, if_pc_seq;
  logic        redirect, flush_if_id, kernel;
  logic [31:0] redirect_pc, epc;
  logic [1:0]  cause;
  logic [2:0]  pending;
`ifdef EXC_MASK_EN
  logic        mask_we;
  logic [1:0]  mask_wdata, mask;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: mode 0 = user, 1 = in handler, 2 = first instruction after return.
  int          m_mode  = 0;
  bit          m_p0    = 0;
  bit          m_p1    = 0;
  logic [31:0] m_epc   = 32'h0;
  int          m_cause = 0;
  bit [1:0]    m_mask  = 2'b00;
  bit          e_take, e_red, e_fl;
  logic [31:0] e_rpc;
  int          e_idx;

  // Samples of the combinational outputs from the most recent cycle.
  logic        s_red, s_fl;
  logic [31:0] s_rpc;

  exception_controller dut (
    .clk         (clk),
    .reset       (reset),
    .timer_irq   (timer_irq),
    .rx_irq      (rx_irq),
    .illegal_inst(illegal_inst),
    .eret        (eret),
    .if_pc       (if_pc),
    .if_pc_seq   (if_pc_seq),
    .if_is_jump  (if_is_jump),
`ifdef EXC_MASK_EN
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .mask        (mask),
`endif
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .flush_if_id (flush_if_id),
    .epc         (epc),
    .cause       (cause),
    .kernel      (kernel),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_comb();
    bit t_ok, r_ok;
    e_take = 0; e_red = 0; e_fl = 0; e_rpc = 32'h0; e_idx = 0;
    t_ok = m_p0 && !m_mask[0];
    r_ok = m_p1 && !m_mask[1];
    if (!reset) begin
      if (m_mode == 0 && !if_pc[31] && (t_ok || r_ok || illegal_inst)) begin
        e_take = 1;
        e_idx  = t_ok ? 0 : (r_ok ? 1 : 2);
        e_red  = 1;
        e_fl   = 1;
        e_rpc  = VecBase + 32'(e_idx * Stride);
      end else if (m_mode == 1 && eret) begin
        e_red = 1;
        e_rpc = m_epc;
      end
    end
  endtask

  task automatic model_seq();
    if (reset) begin
      m_mode = 0; m_p0 = 0; m_p1 = 0; m_epc = 32'h0; m_cause = 0; m_mask = 2'b00;
    end else begin
      if (e_take) begin
        m_epc   = if_is_jump ? if_pc : if_pc_seq;
        m_cause = e_idx;
        if (e_idx == 0) m_p0 = 0;
        if (e_idx == 1) m_p1 = 0;
        m_mode = 1;
      end else if (m_mode == 1 && eret) begin
        m_mode = 2;
      end else if (m_mode == 2) begin
        m_mode = 0;
      end
      if (timer_irq) m_p0 = 1;
      if (rx_irq) m_p1 = 1;
`ifdef EXC_MASK_EN
      if (mask_we) m_mask = mask_wdata;
`endif
    end
  endtask

  task automatic check_now();
    chk("redirect", 32'(redirect), 32'(e_red));
    chk("redirect_pc", redirect_pc, e_rpc);
    chk("flush_if_id", 32'(flush_if_id), 32'(e_fl));
    chk("epc", epc, m_epc);
    chk("cause", 32'(cause), 32'(m_cause));
    chk("kernel", 32'(kernel), 32'(m_mode != 0));
    chk("pending_rx_timer", 32'(pending[1:0]), 32'({m_p1, m_p0}));
`ifdef EXC_MASK_EN
    chk("mask", 32'(mask), 32'(m_mask));
`endif
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    model_comb();
    s_red = redirect;
    s_rpc = redirect_pc;
    s_fl  = flush_if_id;
    check_now();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic idle();
    timer_irq = 0; rx_irq = 0; illegal_inst = 0; eret = 0;
`ifdef EXC_MASK_EN
    mask_we = 0;
`endif
  endtask

  initial begin
    logic [31:0] r;
    reset = 1; if_pc = 32'h100; if_pc_seq = 32'h104; if_is_jump = 0;
    idle();
`ifdef EXC_MASK_EN
    mask_wdata = 2'b00;
`endif
    cycle();
    cycle();
    reset = 0;
    chk("reset_pending", 32'(pending), 32'h0);
    chk("reset_kernel", 32'(kernel), 32'h0);

    // Timer pulse at cycle 5, taken one cycle later.
    repeat (3) cycle();
    timer_irq = 1;
    cycle();
    chk("timer_pulse_no_redirect", 32'(s_red), 32'h0);
    timer_irq = 0;
    cycle();
    chk("timer_take_redirect", 32'(s_red), 32'h1);
    chk("timer_take_pc", s_rpc, 32'h8000_0000);
    chk("timer_take_flush", 32'(s_fl), 32'h1);
    chk("timer_epc", epc, 32'h104);
    chk("timer_cause", 32'(cause), 32'h0);
    chk("timer_kernel", 32'(kernel), 32'h1);
    cycle();
    eret = 1;
    cycle();
    chk("eret_pc", s_rpc, 32'h104);
    chk("eret_no_flush", 32'(s_fl), 32'h0);
    eret = 0;
    cycle();
    cycle();

    // Simultaneous timer and rx: timer first, rx after return and guard.
    timer_irq = 1; rx_irq = 1;
    cycle();
    idle();
    cycle();
    chk("both_timer_first", s_rpc, 32'h8000_0000);
    cycle();
    eret = 1;
    cycle();
    chk("both_eret_pc", s_rpc, 32'h104);
    eret = 0;
    cycle();
    chk("guard_blocks_rx", 32'(s_red), 32'h0);
    cycle();
    chk("rx_take_pc", s_rpc, 32'h8000_0008);
    chk("rx_cause", 32'(cause), 32'h1);
    eret = 1;
    cycle();
    eret = 0;
    cycle();
    cycle();

    // Kernel-space fetch in user mode blocks the take.
    timer_irq = 1;
    cycle();
    timer_irq = 0; if_pc = 32'h8000_0100;
    cycle();
    chk("kspace_blocked", 32'(s_red), 32'h0);
    chk("kspace_no_kernel", 32'(kernel), 32'h0);
    if_pc = 32'h100;
    cycle();
    chk("kspace_released", s_rpc, 32'h8000_0000);
    eret = 1;
    cycle();
    eret = 0;
    cycle();
    cycle();

    // Illegal on a jump: same-cycle take, EPC is the branch itself.
    if_is_jump = 1; if_pc = 32'h200; if_pc_seq = 32'h300; illegal_inst = 1;
    cycle();
    chk("illegal_pc", s_rpc, 32'h8000_0010);
    chk("illegal_epc", epc, 32'h200);
    chk("illegal_cause", 32'(cause), 32'h2);
    cycle();
    chk("illegal_in_kernel_ignored", 32'(s_red), 32'h0);
    illegal_inst = 0; if_is_jump = 0; if_pc = 32'h100; if_pc_seq = 32'h104;
    rx_irq = 1;
    cycle();
    rx_irq = 0;
    cycle();
    chk("kernel_rx_latched", 32'(pending[1]), 32'h1);

    // Reset mid-handler.
    reset = 1;
    cycle();
    reset = 0;
    chk("midreset_kernel", 32'(kernel), 32'h0);
    chk("midreset_pending", 32'(pending), 32'h0);
    chk("midreset_epc", epc, 32'h0);
    eret = 1;
    cycle();
    chk("eret_after_reset", 32'(s_red), 32'h0);
    eret = 0;
    cycle();

`ifdef EXC_MASK_EN
    mask_we = 1; mask_wdata = 2'b01;
    cycle();
    mask_we = 0; timer_irq = 1;
    cycle();
    timer_irq = 0;
    cycle();
    chk("masked_no_redirect", 32'(s_red), 32'h0);
    chk("masked_pending", 32'(pending[0]), 32'h1);
    mask_we = 1; mask_wdata = 2'b00;
    cycle();
    chk("mask_write_cycle", 32'(s_red), 32'h0);
    mask_we = 0;
    cycle();
    chk("unmasked_take", s_rpc, 32'h8000_0000);
    eret = 1;
    cycle();
    eret = 0;
    cycle();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      timer_irq    = ($urandom_range(0, 5) == 0);
      rx_irq       = ($urandom_range(0, 5) == 0);
      illegal_inst = ($urandom_range(0, 7) == 0);
      eret         = ($urandom_range(0, 3) == 0);
      if_is_jump   = ($urandom_range(0, 3) == 0);
      reset        = ($urandom_range(0, 63) == 0);
      r            = $urandom;
      if_pc        = {($urandom_range(0, 7) == 0), r[30:2], 2'b00};
      r            = $urandom;
      if_pc_seq    = {1'b0, r[30:2], 2'b00};
`ifdef EXC_MASK_EN
      mask_we      = ($urandom_range(0, 15) == 0);
      mask_wdata   = 2'($urandom_range(0, 3));
`endif
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
